// File: rtl/core_lsu_mem_responder.sv
// Single-outstanding load/store responder backed by a byte-lane word memory.
// Fixed request-to-response latency; out-of-range accesses return rsp_err with no side effects.
module core_lsu_mem_responder #(
  parameter int               XLEN      = 32,
  parameter int               DEPTH     = 1024,
  parameter logic [XLEN-1:0]  BASE_ADDR = 32'h8000_0000,
  parameter int               LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int NLANES = XLEN / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int AW     = XLEN + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0]    CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [AW-1:0] RANGE_LO = {1'b0, BASE_ADDR};
  localparam logic [AW-1:0] RANGE_HI = RANGE_LO + AW'(4 * DEPTH);

  logic [1:0]        state_reg;
  logic [3:0]        cnt_reg;
  logic              write_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic [NLANES-1:0] wmask_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              in_range_reg;
  logic [XLEN-1:0]   rsp_rdata_reg;
  logic              rsp_err_reg;

  // One extra bit keeps the range check from wrapping at either end of the space.
  logic [AW-1:0]     addr_ext;
  logic [AW-1:0]     offset;
  logic              req_in_range;
  logic [IDX_W-1:0]  req_idx;
  logic              unused_offset_bits;

  assign addr_ext           = {1'b0, req_addr};
  assign offset             = addr_ext - RANGE_LO;
  assign req_in_range       = (addr_ext >= RANGE_LO) && (addr_ext < RANGE_HI);
  assign req_idx            = offset[IDX_W+1:2];
  assign unused_offset_bits = ^{offset[AW-1:IDX_W+2], offset[1:0]};

  // With LATENCY==1 the array is touched on the accept edge itself, so bypass the latches.
  logic              acc_write;
  logic [XLEN-1:0]   acc_wdata;
  logic [NLANES-1:0] acc_wmask;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_in_range;
  logic              enter_resp;
  logic              mem_we;
  logic [XLEN-1:0]   lane_rd;

  always_comb begin
    if (state_reg == IDLE) begin
      acc_write    = req_write;
      acc_wdata    = req_wdata;
      acc_wmask    = req_wmask;
      acc_idx      = req_idx;
      acc_in_range = req_in_range;
    end else begin
      acc_write    = write_reg;
      acc_wdata    = wdata_reg;
      acc_wmask    = wmask_reg;
      acc_idx      = idx_reg;
      acc_in_range = in_range_reg;
    end
  end

  assign enter_resp = ((state_reg == IDLE) && req_valid && (LATENCY == 1)) ||
                      ((state_reg == WAIT) && (cnt_reg == 4'd0));
  assign mem_we     = !rst && enter_resp && acc_write && acc_in_range;

  generate
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (mem_we && acc_wmask[gi]) begin
          lane_mem[acc_idx] <= acc_wdata[gi*8 +: 8];
        end
      end

      assign lane_rd[gi*8 +: 8] = lane_mem[acc_idx];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (enter_resp) begin
        rsp_rdata_reg <= (!acc_write && acc_in_range) ? lane_rd : '0;
        rsp_err_reg   <= !acc_in_range;
      end
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            write_reg    <= req_write;
            wdata_reg    <= req_wdata;
            wmask_reg    <= req_wmask;
            idx_reg      <= req_idx;
            in_range_reg <= req_in_range;
            cnt_reg      <= CNT_INIT;
            state_reg    <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE) && !rst;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_core_lsu_mem_responder.sv
// Scoreboard bench for core_lsu_mem_responder: one instance at LATENCY=1, one at LATENCY=4.
// Expected responses come from a reference memory model and are queued when each request is driven.
module tb_core_lsu_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] model [int];
  int          checks;
  int          failures;

  core_lsu_mem_responder #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  core_lsu_mem_responder #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(4)) dut_l4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit addr_in_range(input logic [31:0] addr);
    logic [32:0] a;
    a = {1'b0, addr};
    return (a >= 33'h0_8000_0000) && (a < 33'h0_8000_1000);
  endfunction

  // Full transaction on instance d; hold = cycles rsp_ready stays low while valid.
  task automatic txn(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] mask, input int hold, input string name);
    exp_t        e;
    exp_t        got;
    bit          inr;
    int          key;
    int          lat;
    int          n;
    logic [31:0] w;
    inr = addr_in_range(addr);
    key = d * 4096 + int'((addr - 32'h8000_0000) >> 2);
    lat = (d == 0) ? 1 : 4;
    if (wr) begin
      e.rdata = 32'h0;
      if (inr) begin
        w = model.exists(key) ? model[key] : 32'h0;
        for (int l = 0; l < 4; l++) begin
          if (mask[l]) w[l*8 +: 8] = wdata[l*8 +: 8];
        end
        model[key] = w;
      end
    end else begin
      e.rdata = (inr && model.exists(key)) ? model[key] : 32'h0;
    end
    e.err = !inr;
    sb_q.push_back(e);

    @(negedge clk);
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready[d]) begin
      failures++;
      $display("FAIL %s ready_timeout got=%0b want=1", name, req_ready[d]);
    end
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wmask[d] = mask;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_wdata[d] = 32'h5A5A_5A5A;
    req_addr[d]  = 32'h8000_0000;

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid[d], req_ready[d]} !== ((k < lat) ? 2'b00 : 2'b10)) begin
        failures++;
        $display("FAIL %s latency_cycle%0d got valid,ready=%b%b want=%b", name, k,
                 rsp_valid[d], req_ready[d], (k < lat) ? 2'b00 : 2'b10);
      end
    end

    e = sb_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      got.rdata = rsp_rdata[d];
      got.err   = rsp_err[d];
      checks++;
      if (!rsp_valid[d] || got !== e) begin
        failures++;
        $display("FAIL %s rsp_hold%0d got valid=%0b rdata=%h err=%0b want valid=1 rdata=%h err=%0b",
                 name, h, rsp_valid[d], got.rdata, got.err, e.rdata, e.err);
      end
      if (h < hold) @(negedge clk);
    end

    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid[d], req_ready[d]} !== 2'b01) begin
      failures++;
      $display("FAIL %s after_handshake got valid,ready=%b%b want=01", name, rsp_valid[d], req_ready[d]);
    end
    $display("txn %s dut=%0d %s addr=%h wdata=%h mask=%h -> rdata=%h err=%0b", name, d,
             wr ? "ST" : "LD", addr, wdata, mask, e.rdata, e.err);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]} !== 35'h0) begin
        failures++;
        $display("FAIL reset_state dut=%0d got ready=%0b valid=%0b rdata=%h err=%0b want all 0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        failures++;
        $display("FAIL reset_release dut=%0d got ready=%0b want=1", d, req_ready[d]);
      end
    end
    $display("txn reset done");
  endtask

  task automatic test_store_load();
    txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, "st_full");
    txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, "ld_full");
    txn(0, 1'b1, 32'h8000_0010, 32'h00AB_0000, 4'b0100, 0, "st_partial");
    txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, "ld_partial");
    txn(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, "st_nomask");
    txn(0, 1'b0, 32'h8000_0013, 32'h0, 4'h0, 0, "ld_unaligned");
  endtask

  task automatic test_latency4();
    txn(1, 1'b1, 32'h8000_0040, 32'h1122_3344, 4'hF, 0, "l4_st");
    txn(1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 5, "l4_ld_hold");
  endtask

  task automatic test_out_of_range();
    txn(0, 1'b1, 32'h8000_0000, 32'h0102_0304, 4'hF, 0, "st_word0");
    txn(0, 1'b1, 32'h8000_0FFC, 32'hA5A5_5A5A, 4'hF, 0, "st_word_last");
    txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, "ld_below");
    txn(0, 1'b0, 32'h8000_1000, 32'h0, 4'h0, 2, "ld_above");
    txn(0, 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, "st_above");
    txn(0, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0, "st_below");
    txn(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, "ld_word0");
    txn(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 0, "ld_word_last");
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h8000_0040;
    req_wdata[1] = 32'hCAFE_BABE;
    req_wmask[1] = 4'hF;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid[1] !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_pre got valid=%0b want=0", rsp_valid[1]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid[1], req_ready[1]} !== 2'b00) begin
      failures++;
      $display("FAIL rst_wait_during got valid,ready=%b%b want=00", rsp_valid[1], req_ready[1]);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({rsp_valid[1], req_ready[1]} !== 2'b01) begin
      failures++;
      $display("FAIL rst_wait_after got valid,ready=%b%b want=01", rsp_valid[1], req_ready[1]);
    end
    $display("txn reset during WAIT of store to 80000040");
    txn(1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 0, "ld_after_rst");
    txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, "ld_l1_kept");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 8; i++) begin
      a = 32'h8000_0100 + 32'(i * 4);
      txn(0, 1'b1, a, $urandom, 4'hF, 0, "b2b_init");
    end
    for (int i = 0; i < 24; i++) begin
      a = 32'h8000_0100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      txn(i % 2, $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2), "b2b_rand");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = 32'h0;
      req_wdata[d] = 32'h0;
      req_wmask[d] = 4'h0;
      rsp_ready[d] = 1'b0;
    end
    rst = 1'b1;
    test_reset();
    test_store_load();
    test_latency4();
    test_out_of_range();
    test_reset_wait();
    // Seed the LATENCY=4 instance's words used by the random mix.
    for (int i = 0; i < 8; i++) begin
      txn(1, 1'b1, 32'h8000_0100 + 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, 0, "l4_seed");
    end
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
